// File: rtl/hwpe_sel_ctrl_pkg.sv
// ============================================================================
// Package : hwpe_sel_ctrl_pkg
// Brief   : Shared state encoding and register map of the HWPE select controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package hwpe_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        DRAIN = 2'd2,
        GATE  = 2'd3
    } hwpe_sel_state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLR    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // The select request is taken from a full byte so out-of-range values can saturate.
    localparam int unsigned SEL_FIELD_LSB = 8;
    localparam int unsigned SEL_FIELD_W   = 8;

    localparam int unsigned STATUS_BUSY_BIT      = 0;
    localparam int unsigned STATUS_SWITCHING_BIT = 1;
    localparam int unsigned STATUS_TIMEOUT_BIT   = 2;

    function automatic logic [1:0] reg_index(input logic [3:2] addr_bits);
        return addr_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hwpe_sel_ctrl_regs.sv
// ============================================================================
// Module  : hwpe_sel_ctrl_regs
// Brief   : Config-bus decode, grant, CTRL/STATUS registers and 1-cycle response.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module hwpe_sel_ctrl_regs
    import hwpe_sel_ctrl_pkg::*;
#(
    parameter int unsigned MAX_NUM_HWPES = 4,
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned SELW          = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_req_i,
    input  logic [31:0]         cfg_add_i,
    input  logic                cfg_wen_i,
    input  logic [31:0]         cfg_wdata_i,
    input  logic [3:0]          cfg_be_i,
    input  logic [ID_WIDTH-1:0] cfg_id_i,
    output logic                cfg_gnt_o,
    output logic [31:0]         cfg_r_rdata_o,
    output logic                cfg_r_valid_o,
    output logic [ID_WIDTH-1:0] cfg_r_id_o,
    input  hwpe_sel_state_e     state,
    input  logic [SELW-1:0]     hwpe_sel,
    input  logic                hwpe_busy,
    input  logic                timeout_set,
    output logic                ctrl_we,
    output logic [SELW-1:0]     wr_sel,
    output logic                wr_en,
    output logic [SELW-1:0]     sel_req,
    output logic                en_req,
    output logic                timeout
);

    localparam logic [SEL_FIELD_W-1:0] SEL_MAX = SEL_FIELD_W'(MAX_NUM_HWPES - 1);

    logic                   write_allowed;
    logic                   granted_write;
    logic                   be_ok;
    logic [1:0]             idx;
    logic                   clr_we;
    logic                   switching;
    logic [SEL_FIELD_W-1:0] sel_field;
    logic [31:0]            rdata_next;
    logic                   unused_bits;

    // Writes stall while a switch is in flight; reads are always served.
    assign write_allowed = (state == OFF) || (state == ON);
    assign cfg_gnt_o     = cfg_req_i && (cfg_wen_i || write_allowed);
    assign granted_write = cfg_gnt_o && !cfg_wen_i;
    assign be_ok         = cfg_be_i[0] && cfg_be_i[1];
    assign idx           = reg_index(cfg_add_i[3:2]);
    assign ctrl_we       = granted_write && be_ok && (idx == REG_CTRL);
    assign clr_we        = granted_write && be_ok && (idx == REG_CLR);
    assign switching     = (state == DRAIN) || (state == GATE);

    assign sel_field = cfg_wdata_i[SEL_FIELD_LSB +: SEL_FIELD_W];
    assign wr_sel    = (sel_field > SEL_MAX) ? SEL_MAX[SELW-1:0] : sel_field[SELW-1:0];
    assign wr_en     = cfg_wdata_i[0];

    assign unused_bits = ^{cfg_add_i[31:4], cfg_add_i[1:0], cfg_wdata_i[31:16],
                           cfg_wdata_i[7:1], cfg_be_i[3:2]};

    always_comb begin
        rdata_next = '0;
        case (idx)
            REG_CTRL: begin
                rdata_next[SEL_FIELD_LSB +: SELW] = sel_req;
                rdata_next[0]                     = en_req;
            end
            REG_STATUS: begin
                rdata_next[SEL_FIELD_LSB +: SELW]   = hwpe_sel;
                rdata_next[STATUS_TIMEOUT_BIT]      = timeout;
                rdata_next[STATUS_SWITCHING_BIT]    = switching;
                rdata_next[STATUS_BUSY_BIT]         = hwpe_busy;
            end
            default: rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_r_valid_o <= 1'b0;
            cfg_r_rdata_o <= '0;
            cfg_r_id_o    <= '0;
            sel_req       <= '0;
            en_req        <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            cfg_r_valid_o <= cfg_gnt_o;
            if (cfg_gnt_o) begin
                cfg_r_id_o    <= cfg_id_i;
                cfg_r_rdata_o <= cfg_wen_i ? rdata_next : '0;
            end
            if (ctrl_we) begin
                sel_req <= wr_sel;
                en_req  <= wr_en;
            end else if (timeout_set) begin
                en_req  <= 1'b0;
            end
            if (timeout_set) begin
                timeout <= 1'b1;
            end else if (clr_we) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hwpe_sel_ctrl.sv
// ============================================================================
// Module  : hwpe_sel_ctrl
// Brief   : Owns HWPE enable/select; drains the busy engine, gates, switches.
//           `HWPE_SEL_CTRL_EVT_EN enables the switch-done event pulse on evt_o.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module hwpe_sel_ctrl
    import hwpe_sel_ctrl_pkg::*;
#(
    parameter  int unsigned MAX_NUM_HWPES = 4,
    parameter  int unsigned ID_WIDTH      = 8,
    parameter  int unsigned GATE_CYCLES   = 2,
    parameter  int unsigned DRAIN_TIMEOUT = 1024,
    localparam int unsigned SELW          = (MAX_NUM_HWPES > 1) ? $clog2(MAX_NUM_HWPES) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_req_i,
    input  logic [31:0]         cfg_add_i,
    input  logic                cfg_wen_i,
    input  logic [31:0]         cfg_wdata_i,
    input  logic [3:0]          cfg_be_i,
    input  logic [ID_WIDTH-1:0] cfg_id_i,
    output logic                cfg_gnt_o,
    output logic [31:0]         cfg_r_rdata_o,
    output logic                cfg_r_valid_o,
    output logic [ID_WIDTH-1:0] cfg_r_id_o,
    input  logic                hwpe_busy_i,
    output logic                hwpe_en_o,
    output logic [SELW-1:0]     hwpe_sel_o,
    output logic                evt_o
);

    localparam int unsigned CNT_MAX = (DRAIN_TIMEOUT > GATE_CYCLES) ? DRAIN_TIMEOUT : GATE_CYCLES;
    localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(DRAIN_TIMEOUT - 1);
    localparam logic [CNTW-1:0] GATE_LOAD  = CNTW'(GATE_CYCLES - 1);

    hwpe_sel_state_e state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            en_q;
    logic            evt_d;
    logic            timeout_set;
    logic            ctrl_we;
    logic [SELW-1:0] wr_sel;
    logic            wr_en;
    logic [SELW-1:0] sel_req;
    logic            en_req;
    logic            timeout;

    hwpe_sel_ctrl_regs #(
        .MAX_NUM_HWPES (MAX_NUM_HWPES),
        .ID_WIDTH      (ID_WIDTH),
        .SELW          (SELW)
    ) u_regs (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_req_i     (cfg_req_i),
        .cfg_add_i     (cfg_add_i),
        .cfg_wen_i     (cfg_wen_i),
        .cfg_wdata_i   (cfg_wdata_i),
        .cfg_be_i      (cfg_be_i),
        .cfg_id_i      (cfg_id_i),
        .cfg_gnt_o     (cfg_gnt_o),
        .cfg_r_rdata_o (cfg_r_rdata_o),
        .cfg_r_valid_o (cfg_r_valid_o),
        .cfg_r_id_o    (cfg_r_id_o),
        .state         (state_q),
        .hwpe_sel      (sel_q),
        .hwpe_busy     (hwpe_busy_i),
        .timeout_set   (timeout_set),
        .ctrl_we       (ctrl_we),
        .wr_sel        (wr_sel),
        .wr_en         (wr_en),
        .sel_req       (sel_req),
        .en_req        (en_req),
        .timeout       (timeout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        timeout_set = 1'b0;
        evt_d       = 1'b0;
        case (state_q)
            OFF: begin
                if (ctrl_we && wr_en) begin
                    state_d = ON;
                    sel_d   = wr_sel;
                    evt_d   = 1'b1;
                end
            end
            ON: begin
                if (ctrl_we && ((wr_sel != sel_q) || !wr_en)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (!hwpe_busy_i) begin
                    state_d = GATE;
                    cnt_d   = GATE_LOAD;
                end else if (cnt_q == DRAIN_LAST) begin
                    // Abandon the drain; the regs clear en_req so GATE lands in OFF.
                    timeout_set = 1'b1;
                    state_d     = GATE;
                    cnt_d       = GATE_LOAD;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            GATE: begin
                if (cnt_q == '0) begin
                    sel_d   = sel_req;
                    state_d = en_req ? ON : OFF;
                    evt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: state_d = OFF;
        endcase
    end

    // Enable is registered so the clock gate never sees a decode glitch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= OFF;
            cnt_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= (state_d == ON) || (state_d == DRAIN);
        end
    end

    assign hwpe_en_o  = en_q;
    assign hwpe_sel_o = sel_q;

`ifdef HWPE_SEL_CTRL_EVT_EN
    logic evt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_o = evt_q;
`else
    logic unused_evt;

    assign unused_evt = evt_d;
    assign evt_o      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hwpe_sel_ctrl.sv
// ============================================================================
// Module  : tb_hwpe_sel_ctrl
// Brief   : Self-checking bench: vector table, corner sequences, random vs model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_hwpe_sel_ctrl;

    localparam int unsigned N_HWPE = 4;
    localparam int unsigned IDW    = 8;
    localparam int unsigned GATE   = 2;
    localparam int unsigned TMO    = 16;
    localparam int unsigned SELW   = 2;

`ifdef HWPE_SEL_CTRL_EVT_EN
    localparam bit EVT_ON = 1'b1;
`else
    localparam bit EVT_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_req, cfg_wen;
    logic [31:0]     cfg_add, cfg_wdata;
    logic [3:0]      cfg_be;
    logic [IDW-1:0]  cfg_id;
    logic            cfg_gnt;
    logic [31:0]     cfg_r_rdata;
    logic            cfg_r_valid;
    logic [IDW-1:0]  cfg_r_id;
    logic            hwpe_busy;
    logic            hwpe_en;
    logic [SELW-1:0] hwpe_sel;
    logic            evt;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the controller used during the random phase.
    int m_sel, m_sel_req, m_en_req, m_timeout;
    int m_run, m_drain, m_age, m_gate;

    always #5 clk = ~clk;

    hwpe_sel_ctrl #(
        .MAX_NUM_HWPES (N_HWPE),
        .ID_WIDTH      (IDW),
        .GATE_CYCLES   (GATE),
        .DRAIN_TIMEOUT (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_req_i     (cfg_req),
        .cfg_add_i     (cfg_add),
        .cfg_wen_i     (cfg_wen),
        .cfg_wdata_i   (cfg_wdata),
        .cfg_be_i      (cfg_be),
        .cfg_id_i      (cfg_id),
        .cfg_gnt_o     (cfg_gnt),
        .cfg_r_rdata_o (cfg_r_rdata),
        .cfg_r_valid_o (cfg_r_valid),
        .cfg_r_id_o    (cfg_r_id),
        .hwpe_busy_i   (hwpe_busy),
        .hwpe_en_o     (hwpe_en),
        .hwpe_sel_o    (hwpe_sel),
        .evt_o         (evt)
    );

    typedef struct {
        logic        req;
        logic        wen;
        logic [31:0] add;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [7:0]  id;
        logic        gnt;
        logic [31:0] rdata;
        logic        en;
        logic [1:0]  sel;
        logic        ev;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic wen, input logic [31:0] add,
                         input logic [31:0] wd, input logic [3:0] be, input logic [7:0] id);
        cfg_req   = req;
        cfg_wen   = wen;
        cfg_add   = add;
        cfg_wdata = wd;
        cfg_be    = be;
        cfg_id    = id;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 8'h0);
    endtask

    task automatic chk_out(input string name, input logic en, input logic [1:0] sel);
        chk({name, "_en"}, 32'(hwpe_en), 32'(en));
        chk({name, "_sel"}, 32'(hwpe_sel), 32'(sel));
    endtask

    task automatic rand_cycle(input int mode);
        logic        rq, wn;
        logic [31:0] ad, wd, rd;
        logic [3:0]  be;
        logic [7:0]  id;
        bit          exp_gnt, wr_ok, ctrl_w, clr_w, ev;
        int          idx, nsel, nen;
        rq = ($urandom_range(0, 3) != 0);
        wn = ($urandom_range(0, 1) == 1);
        ad = $urandom();
        wd = $urandom();
        wd[15:8] = 8'($urandom_range(0, 7));
        wd[0] = ($urandom_range(0, 3) != 0);
        be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
        id = 8'($urandom());
        case (mode)
            0:       hwpe_busy = ($urandom_range(0, 1) == 1);
            1:       hwpe_busy = 1'b1;
            default: hwpe_busy = 1'b0;
        endcase
        drive(rq, wn, ad, wd, be, id);

        exp_gnt = rq && (wn || !(m_drain != 0 || m_gate > 0));
        chk("rnd_gnt", 32'(cfg_gnt), 32'(exp_gnt));
        idx = int'(ad[3:2]);
        rd = 32'h0;
        if (idx == 0) rd = 32'((m_sel_req << 8) | m_en_req);
        if (idx == 1) rd = 32'((m_sel << 8) | (m_timeout << 2) |
                               ((m_drain != 0 || m_gate > 0) ? 2 : 0) | (hwpe_busy ? 1 : 0));

        wr_ok  = exp_gnt && !wn && be[0] && be[1];
        ctrl_w = wr_ok && (idx == 0);
        clr_w  = wr_ok && (idx == 2);
        nsel   = (int'(wd[15:8]) > N_HWPE - 1) ? N_HWPE - 1 : int'(wd[15:8]);
        nen    = wd[0] ? 1 : 0;
        ev     = 1'b0;
        if (m_gate > 0) begin
            if (m_gate == 1) begin
                m_gate = 0;
                m_sel  = m_sel_req;
                m_run  = m_en_req;
                ev     = 1'b1;
            end else begin
                m_gate--;
            end
        end else if (m_drain != 0) begin
            if (!hwpe_busy) begin
                m_drain = 0;
                m_gate  = GATE;
            end else if (m_age == TMO - 1) begin
                m_drain   = 0;
                m_gate    = GATE;
                m_timeout = 1;
                m_en_req  = 0;
            end else begin
                m_age++;
            end
        end else if (m_run != 0) begin
            if (ctrl_w && (nsel != m_sel || nen == 0)) begin
                m_run   = 0;
                m_drain = 1;
                m_age   = 0;
            end
        end else if (ctrl_w && nen != 0) begin
            m_run = 1;
            m_sel = nsel;
            ev    = 1'b1;
        end
        if (ctrl_w) begin
            m_sel_req = nsel;
            m_en_req  = nen;
        end
        if (clr_w) m_timeout = 0;

        tick();
        chk("rnd_rvalid", 32'(cfg_r_valid), 32'(exp_gnt));
        if (exp_gnt) chk("rnd_rid", 32'(cfg_r_id), 32'(id));
        if (exp_gnt && wn) chk("rnd_rdata", cfg_r_rdata, rd);
        chk("rnd_en", 32'(hwpe_en), 32'((m_run != 0 || m_drain != 0) ? 1 : 0));
        chk("rnd_sel", 32'(hwpe_sel), 32'(m_sel));
        chk("rnd_evt", 32'(evt), 32'(EVT_ON && ev));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h4, 32'h0,        4'hf, 8'h01, 1'b1, 32'h0,   1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0, 32'h0,        4'hf, 8'h02, 1'b1, 32'h0,   1'b0, 2'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0, 32'h201,      4'hf, 8'h03, 1'b1, 32'h0,   1'b1, 2'd2, EVT_ON};
        vecs[3]  = '{1'b1, 1'b1, 32'h0, 32'h0,        4'hf, 8'h04, 1'b1, 32'h201, 1'b1, 2'd2, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h4, 32'h0,        4'hf, 8'h05, 1'b1, 32'h200, 1'b1, 2'd2, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0, 32'h201,      4'hf, 8'h06, 1'b1, 32'h0,   1'b1, 2'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0, 32'h100,      4'h1, 8'h07, 1'b1, 32'h0,   1'b1, 2'd2, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h4, 32'hffffffff, 4'hf, 8'h08, 1'b1, 32'h0,   1'b1, 2'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'hc, 32'h301,      4'hf, 8'h09, 1'b1, 32'h0,   1'b1, 2'd2, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'hc, 32'h0,        4'hf, 8'h0a, 1'b1, 32'h0,   1'b1, 2'd2, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h0, 32'h0,        4'hf, 8'h0b, 1'b1, 32'h201, 1'b1, 2'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h0, 32'h0,        4'h0, 8'h00, 1'b0, 32'h0,   1'b1, 2'd2, 1'b0};

        rst       = 1'b1;
        hwpe_busy = 1'b0;
        idle();
        chk("rst_en", 32'(hwpe_en), 0);
        chk("rst_sel", 32'(hwpe_sel), 0);
        chk("rst_rvalid", 32'(cfg_r_valid), 0);
        chk("rst_rdata", cfg_r_rdata, 0);
        chk("rst_rid", 32'(cfg_r_id), 0);
        chk("rst_evt", 32'(evt), 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Register access table starting from OFF with an idle engine.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].req, vecs[i].wen, vecs[i].add, vecs[i].wdata, vecs[i].be, vecs[i].id);
            chk($sformatf("vec%0d_gnt", i), 32'(cfg_gnt), 32'(vecs[i].gnt));
            tick();
            chk($sformatf("vec%0d_rvalid", i), 32'(cfg_r_valid), 32'(vecs[i].gnt));
            if (vecs[i].gnt) chk($sformatf("vec%0d_rid", i), 32'(cfg_r_id), 32'(vecs[i].id));
            if (vecs[i].gnt && vecs[i].wen) chk($sformatf("vec%0d_rdata", i), cfg_r_rdata, vecs[i].rdata);
            chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].sel);
            chk($sformatf("vec%0d_evt", i), 32'(evt), 32'(vecs[i].ev));
        end

        // Switch 2 -> 1 under a busy engine.
        hwpe_busy = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h101, 4'hf, 8'h20);
        chk("swA_gnt", 32'(cfg_gnt), 1);
        tick();
        chk("swA_rid", 32'(cfg_r_id), 32'h20);
        chk_out("swA_drain", 1'b1, 2'd2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h301, 4'hf, 8'h21);
            chk("swA_stall_gnt", 32'(cfg_gnt), 0);
            tick();
            chk("swA_stall_rvalid", 32'(cfg_r_valid), 0);
            chk_out("swA_stall", 1'b1, 2'd2);
        end
        drive(1'b1, 1'b1, 32'h4, 32'h0, 4'hf, 8'h22);
        chk("swA_rd_gnt", 32'(cfg_gnt), 1);
        tick();
        chk("swA_status", cfg_r_rdata, 32'h203);
        hwpe_busy = 1'b0;
        idle();
        tick();
        chk_out("swA_gate1", 1'b0, 2'd2);
        tick();
        chk_out("swA_gate2", 1'b0, 2'd2);
        tick();
        chk_out("swA_on", 1'b1, 2'd1);
        chk("swA_evt", 32'(evt), 32'(EVT_ON));
        tick();
        chk("swA_evt_end", 32'(evt), 0);

        // Drain timeout with busy stuck high.
        hwpe_busy = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h001, 4'hf, 8'h30);
        tick();
        idle();
        repeat (15) tick();
        chk_out("to_last_drain", 1'b1, 2'd1);
        tick();
        chk_out("to_gate", 1'b0, 2'd1);
        tick();
        tick();
        chk_out("to_off", 1'b0, 2'd0);
        chk("to_evt", 32'(evt), 32'(EVT_ON));
        drive(1'b1, 1'b1, 32'h4, 32'h0, 4'hf, 8'h31);
        tick();
        chk("to_status", cfg_r_rdata, 32'h5);
        drive(1'b1, 1'b1, 32'h0, 32'h0, 4'hf, 8'h32);
        tick();
        chk("to_ctrl", cfg_r_rdata, 32'h0);
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h3, 8'h33);
        chk("clr_gnt", 32'(cfg_gnt), 1);
        tick();
        drive(1'b1, 1'b1, 32'h4, 32'h0, 4'hf, 8'h34);
        tick();
        chk("clr_status", cfg_r_rdata, 32'h1);
        hwpe_busy = 1'b0;

        // Out-of-range select saturates.
        drive(1'b1, 1'b0, 32'h0, 32'h701, 4'hf, 8'h40);
        tick();
        chk_out("sat", 1'b1, 2'd3);
        chk("sat_evt", 32'(evt), 32'(EVT_ON));
        drive(1'b1, 1'b1, 32'h0, 32'h0, 4'hf, 8'h41);
        tick();
        chk("sat_ctrl", cfg_r_rdata, 32'h301);

        // Back-to-back reads.
        drive(1'b1, 1'b1, 32'h4, 32'h0, 4'hf, 8'h05);
        tick();
        chk("b2b_v0", 32'(cfg_r_valid), 1);
        chk("b2b_id0", 32'(cfg_r_id), 5);
        drive(1'b1, 1'b1, 32'h4, 32'h0, 4'hf, 8'h06);
        tick();
        chk("b2b_v1", 32'(cfg_r_valid), 1);
        chk("b2b_id1", 32'(cfg_r_id), 6);
        idle();
        tick();
        chk("b2b_v2", 32'(cfg_r_valid), 0);

        // Asynchronous reset while the clock is gated mid-switch.
        drive(1'b1, 1'b0, 32'h0, 32'h001, 4'hf, 8'h50);
        tick();
        idle();
        tick();
        chk_out("rstg_gate", 1'b0, 2'd3);
        drive(1'b1, 1'b1, 32'h0, 32'h0, 4'hf, 8'h51);
        #2 rst = 1'b1;
        #1;
        chk_out("rstg_async", 1'b0, 2'd0);
        chk("rstg_rvalid", 32'(cfg_r_valid), 0);
        idle();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        chk("rstg_no_rvalid", 32'(cfg_r_valid), 0);
        chk_out("rstg_after", 1'b0, 2'd0);

        // Random traffic against the model, starting from reset state.
        m_sel = 0; m_sel_req = 0; m_en_req = 0; m_timeout = 0;
        m_run = 0; m_drain = 0; m_age = 0; m_gate = 0;
        for (int seg = 0; seg < 20; seg++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            for (int c = 0; c < 30; c++) rand_cycle(mode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
